pwm_counter_ctrl: RTL
=====================

Name: pwm_counter_ctrl

Overview:
- Sequencing controller for the PWM period counter: drives its enable, count_reset, period, prescale and direction inputs, and watches its count_val output.
- Holds CPU-written settings in shadow registers and applies them glitch-free only at a counter wrap (period boundary).
- Provides start/stop control, a one-shot mode that stops after N periods, and per-period event pulses.
- Sits between the register file and the counter instance.

Parameters:
- RST_PERIOD, 16'hFFFF, reset value of the shadow and active period.
- RST_PRESCALE, 8'h00, reset value of the shadow and active prescale.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_wr  in  1  one-cycle pulse; latches cfg_period, cfg_prescale and cfg_upnotdown into the shadow registers
- cfg_period  in  16  requested period
- cfg_prescale  in  8  requested prescale exponent
- cfg_upnotdown  in  1  requested direction: 1 = up, 0 = down
- cmd_start  in  1  one-cycle pulse; start or restart the counter from 0
- cmd_stop  in  1  one-cycle pulse; pause the counter
- oneshot_en  in  1  enable one-shot mode; sampled at start
- repeat_cnt  in  8  number of periods in one-shot mode; sampled at start
- count_val  in  16  counter value
- ctr_en  out  1  counter enable
- ctr_count_reset  out  1  counter synchronous clear
- ctr_period  out  16  active period
- ctr_prescale  out  8  active prescale
- ctr_upnotdown  out  1  active direction
- period_evt  out  1  one-cycle pulse per counted wrap
- done  out  1  one-cycle pulse when a one-shot run completes
- busy  out  1  high in START or RUN
- update_pending  out  1  shadow holds settings not yet applied

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - ctr_en, ctr_count_reset, period_evt, done, busy, update_pending = 0.
  - Shadow and active period = RST_PERIOD; prescale = RST_PRESCALE; upnotdown = 1.
  - Remaining-period counter and first-wrap mask cleared.
  - A reset mid-run aborts the run immediately; no done pulse.
- All outputs are registered.
- cfg_wr:
  - Shadow <= cfg values at the next edge; update_pending <= 1.
  - cfg_period values 0 and 1 are clamped to 2.
- States:
  - IDLE: ctr_en=0.
    - cmd_start -> START.
  - START: lasts exactly one cycle. ctr_count_reset=1, ctr_en=0.
    - If update_pending: active <= shadow and update_pending <= 0.
    - Latch oneshot_en and repeat_cnt.
    - Load remaining <= repeat_cnt.
    - Set first_mask = ~upnotdown of the new active direction.
    - -> RUN.
  - RUN: ctr_en=1, ctr_count_reset=0.
    - cmd_stop -> IDLE: ctr_en=0 from the next cycle; count_val is frozen, not cleared.
    - cmd_start -> START (restart).
- Simultaneous cmd_start and cmd_stop: stop wins.
- Wrap detection:
  - Register prev_count <= count_val every cycle.
  - Detection is suppressed in the first RUN cycle after START.
  - Up wrap: prev_count == ctr_period-1 and count_val == 0.
  - Down wrap: prev_count == 0 and count_val == ctr_period-1.
  - In down mode, the first down wrap after START (the initial 0 -> period-1 load) only clears first_mask. It is not counted.
- On a counted wrap (wrap_evt):
  - period_evt=1 next cycle.
  - If update_pending: active <= shadow (all three fields together) and update_pending <= 0.
  - cfg_wr in the same cycle as wrap_evt: the apply uses the pre-write shadow; update_pending stays 1 for the newly written values.
- One-shot completion:
  - Applies when the latched oneshot_en=1 and repeat_cnt != 0.
  - Each counted wrap decrements remaining.
  - The wrap that makes remaining 0 gives: done=1, ctr_en=0 and a one-cycle ctr_count_reset (count_val returns to 0), then -> IDLE.
  - period_evt is also pulsed on that wrap.
- oneshot_en=0 or repeat_cnt=0: run continuously until stopped.
- busy = (state != IDLE).

Test Plan:
- Reset, then cfg_wr (period=5, prescale=0, up), cmd_start -> ctr_count_reset high 1 cycle with ctr_period=5. Then ctr_en=1, count 0..4 repeating, and period_evt once per 5 counts. Reset values are checked first: ctr_period=16'hFFFF, ctr_upnotdown=1, all strobes 0.
- Running with period=5: cfg_wr period=3 mid-period -> update_pending=1 and ctr_period stays 5 until the wrap 4->0. Then ctr_period=3, update_pending=0, and the counter cycles 0..2.
- oneshot_en=1, repeat_cnt=3, period=4, prescale=1 -> exactly 3 period_evt pulses. done coincides with the 3rd; then ctr_en=0, count_val=0, busy=0.
- Down mode, period=4, oneshot repeat_cnt=2 -> initial 0->3 transition not counted. done after the sequence 3,2,1,0,3,2,1,0,3.
- cmd_start and cmd_stop in the same cycle while in RUN -> IDLE, count_val frozen. A later cmd_start restarts from 0.
- cfg_wr with period=0 -> shadow clamped to 2. rst_n low during a one-shot run -> IDLE next edge, no done pulse, all outputs at reset values.

Source files
------------

// File: rtl/pwm_counter_ctrl.sv
// rtl/pwm_counter_ctrl.sv - sequencing controller for the PWM period counter
// Shadowed settings are applied only at START or at a counted wrap.
module pwm_counter_ctrl #(
  parameter logic [15:0] RST_PERIOD   = 16'hFFFF,
  parameter logic [7:0]  RST_PRESCALE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_prescale,
  input  logic        cfg_upnotdown,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        oneshot_en,
  input  logic [7:0]  repeat_cnt,
  input  logic [15:0] count_val,
  output logic        ctr_en,
  output logic        ctr_count_reset,
  output logic [15:0] ctr_period,
  output logic [7:0]  ctr_prescale,
  output logic        ctr_upnotdown,
  output logic        period_evt,
  output logic        done,
  output logic        busy,
  output logic        update_pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_shadow_period;
  logic [7:0]  r_shadow_prescale;
  logic        r_shadow_updn;
  logic [15:0] r_act_period;
  logic [7:0]  r_act_prescale;
  logic        r_act_updn;
  logic        r_update_pending;

  logic [15:0] r_prev_count;
  logic        r_first_run;
  logic        r_first_mask;
  logic        r_os_en;
  logic [7:0]  r_remaining;

  logic        r_ctr_en;
  logic        r_ctr_count_reset;
  logic        r_period_evt;
  logic        r_done;
  logic        r_busy;

  logic [15:0] w_cfg_period;
  logic [15:0] w_period_m1;
  logic        w_new_dir;
  logic        w_up_wrap;
  logic        w_dn_wrap;
  logic        w_raw_wrap;
  logic        w_wrap_evt;
  logic        w_enter_start;
  logic        w_os_done;
  logic        w_apply;

  assign w_cfg_period = (cfg_period < 16'd2) ? 16'd2 : cfg_period;
  assign w_period_m1  = r_act_period - 16'd1;
  assign w_new_dir    = r_update_pending ? r_shadow_updn : r_act_updn;

  // The first RUN cycle compares against a stale prev_count, so it is ignored.
  assign w_up_wrap  = (r_prev_count == w_period_m1) && (count_val == 16'd0);
  assign w_dn_wrap  = (r_prev_count == 16'd0) && (count_val == w_period_m1);
  assign w_raw_wrap = (r_state == RUN) && !r_first_run &&
                      (r_act_updn ? w_up_wrap : w_dn_wrap);
  assign w_wrap_evt = w_raw_wrap && !r_first_mask;
  assign w_apply    = r_update_pending && (w_enter_start || w_wrap_evt);

  always_comb begin
    w_state_nxt   = r_state;
    w_enter_start = 1'b0;
    w_os_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_start && !cmd_stop) begin
          w_state_nxt   = START;
          w_enter_start = 1'b1;
        end
      end
      START: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (cmd_stop) begin
          w_state_nxt = IDLE;
        end else if (cmd_start) begin
          w_state_nxt   = START;
          w_enter_start = 1'b1;
        end else if (w_wrap_evt && r_os_en && (r_remaining == 8'd1)) begin
          w_state_nxt = IDLE;
          w_os_done   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow_period   <= RST_PERIOD;
      r_shadow_prescale <= RST_PRESCALE;
      r_shadow_updn     <= 1'b1;
      r_act_period      <= RST_PERIOD;
      r_act_prescale    <= RST_PRESCALE;
      r_act_updn        <= 1'b1;
      r_update_pending  <= 1'b0;
      r_prev_count      <= 16'd0;
      r_first_run       <= 1'b0;
      r_first_mask      <= 1'b0;
      r_os_en           <= 1'b0;
      r_remaining       <= 8'd0;
      r_ctr_en          <= 1'b0;
      r_ctr_count_reset <= 1'b0;
      r_period_evt      <= 1'b0;
      r_done            <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      r_prev_count      <= count_val;
      r_first_run       <= (r_state == START);
      r_ctr_en          <= (w_state_nxt == RUN);
      r_ctr_count_reset <= (w_state_nxt == START) || w_os_done;
      r_period_evt      <= w_wrap_evt;
      r_done            <= w_os_done;
      r_busy            <= (w_state_nxt != IDLE);

      if (w_apply) begin
        r_act_period     <= r_shadow_period;
        r_act_prescale   <= r_shadow_prescale;
        r_act_updn       <= r_shadow_updn;
        r_update_pending <= 1'b0;
      end
      // A write landing on an apply cycle stays pending for the next boundary.
      if (cfg_wr) begin
        r_shadow_period   <= w_cfg_period;
        r_shadow_prescale <= cfg_prescale;
        r_shadow_updn     <= cfg_upnotdown;
        r_update_pending  <= 1'b1;
      end

      if (w_enter_start) begin
        r_os_en      <= oneshot_en && (repeat_cnt != 8'd0);
        r_remaining  <= repeat_cnt;
        r_first_mask <= ~w_new_dir;
      end else begin
        if (w_wrap_evt && (r_remaining != 8'd0)) begin
          r_remaining <= r_remaining - 8'd1;
        end
        if (w_raw_wrap && r_first_mask) begin
          r_first_mask <= 1'b0;
        end
      end
    end
  end

  assign ctr_en          = r_ctr_en;
  assign ctr_count_reset = r_ctr_count_reset;
  assign ctr_period      = r_act_period;
  assign ctr_prescale    = r_act_prescale;
  assign ctr_upnotdown   = r_act_updn;
  assign period_evt      = r_period_evt;
  assign done            = r_done;
  assign busy            = r_busy;
  assign update_pending  = r_update_pending;

endmodule
